// File: rtl/apb_proc_driver_if.sv
// rtl/apb_proc_driver_if.sv - request/response bus between apb_proc_driver and the APB master
interface apb_proc_driver_if;
   logic       start;
   logic       write;
   logic [1:0] sel;
   logic [7:0] addr;
   logic [7:0] wdata;
   logic [7:0] wait_cycles;
   logic [7:0] rdata;
   logic       ready;

   modport master (output start, write, sel, addr, wdata, wait_cycles, input rdata, ready);
   modport slave  (input start, write, sel, addr, wdata, wait_cycles, output rdata, ready);
endinterface

// File: rtl/apb_proc_driver.sv
// rtl/apb_proc_driver.sv - queued command initiator for the APB master with timeout and response FIFO
module apb_proc_driver #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [1:0]        cmd_sel,
   input  logic [7:0]        cmd_addr,
   input  logic [7:0]        cmd_wdata,
   input  logic [7:0]        cmd_wait,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [7:0]        rsp_data,
   output logic              rsp_err,
   output logic              rsp_write,
   output logic              busy,
   apb_proc_driver_if.master pb
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL        = CW'(DEPTH);
   localparam logic [9:0]    TIMEOUT_EXT = 10'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, START, WAIT, REJECT} state_t;
   state_t state_q, state_d;

   // command entry layout: {write, sel, addr, wdata, wait}
   logic [26:0]   cmd_mem [DEPTH];
   logic [AW-1:0] cmd_wptr, cmd_rptr;
   logic [CW-1:0] cmd_count;
   logic          cmd_push, cmd_pop;
   logic [26:0]   head;

   logic [9:0]    rsp_mem [DEPTH];
   logic [AW-1:0] rsp_wptr, rsp_rptr;
   logic [CW-1:0] rsp_count;
   logic          rsp_push, rsp_pop, rsp_full;
   logic [9:0]    rsp_entry;

   logic [9:0]    timer_q;
   logic          load_fields;

   assign cmd_ready = (cmd_count != FULL);
   assign cmd_push  = cmd_valid && cmd_ready;
   assign head      = cmd_mem[cmd_rptr];

   assign rsp_valid = (rsp_count != '0);
   assign rsp_full  = (rsp_count == FULL);
   assign rsp_pop   = rsp_valid && rsp_ready;
   assign {rsp_data, rsp_err, rsp_write} = rsp_mem[rsp_rptr];

   assign pb.start = (state_q == START);
   assign busy     = (state_q != IDLE) || (cmd_count != '0);

   always_ff @(posedge clk) begin
      if (cmd_push) cmd_mem[cmd_wptr] <= {cmd_write, cmd_sel, cmd_addr, cmd_wdata, cmd_wait};
      if (rsp_push) rsp_mem[rsp_wptr] <= rsp_entry;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cmd_wptr  <= '0;
         cmd_rptr  <= '0;
         cmd_count <= '0;
         rsp_wptr  <= '0;
         rsp_rptr  <= '0;
         rsp_count <= '0;
      end else begin
         if (cmd_push) cmd_wptr <= cmd_wptr + AW'(1);
         if (cmd_pop)  cmd_rptr <= cmd_rptr + AW'(1);
         if (cmd_push && !cmd_pop)      cmd_count <= cmd_count + CW'(1);
         else if (!cmd_push && cmd_pop) cmd_count <= cmd_count - CW'(1);
         if (rsp_push) rsp_wptr <= rsp_wptr + AW'(1);
         if (rsp_pop)  rsp_rptr <= rsp_rptr + AW'(1);
         if (rsp_push && !rsp_pop)      rsp_count <= rsp_count + CW'(1);
         else if (!rsp_push && rsp_pop) rsp_count <= rsp_count - CW'(1);
      end
   end

   // pb_* fields change only when a transfer is launched; they hold through WAIT and after
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= IDLE;
         timer_q        <= '0;
         pb.write       <= 1'b0;
         pb.sel         <= 2'd0;
         pb.addr        <= 8'h00;
         pb.wdata       <= 8'h00;
         pb.wait_cycles <= 8'h00;
      end else begin
         state_q <= state_d;
         if (load_fields) begin
            pb.write       <= head[26];
            pb.sel         <= head[25:24];
            pb.addr        <= head[23:16];
            pb.wdata       <= head[15:8];
            pb.wait_cycles <= head[7:0];
         end
         if (state_q == START)
            timer_q <= {2'b00, pb.wait_cycles} + TIMEOUT_EXT;
         else if (state_q == WAIT && timer_q != '0)
            timer_q <= timer_q - 10'd1;
      end
   end

   always_comb begin
      state_d     = state_q;
      cmd_pop     = 1'b0;
      rsp_push    = 1'b0;
      rsp_entry   = '0;
      load_fields = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_count != '0 && !rsp_full) begin
               if (head[25:24] == 2'd0) begin
                  state_d = REJECT;
               end else begin
                  state_d     = START;
                  load_fields = 1'b1;
               end
            end
         end
         START: state_d = WAIT;
         WAIT: begin
            // a ready arriving in the expiry cycle still completes the transfer
            if (pb.ready) begin
               cmd_pop   = 1'b1;
               rsp_push  = 1'b1;
               rsp_entry = {(pb.write ? 8'h00 : pb.rdata), 1'b0, pb.write};
               state_d   = IDLE;
            end else if (timer_q == '0) begin
               cmd_pop   = 1'b1;
               rsp_push  = 1'b1;
               rsp_entry = {8'h00, 1'b1, pb.write};
               state_d   = IDLE;
            end
         end
         REJECT: begin
            cmd_pop   = 1'b1;
            rsp_push  = 1'b1;
            rsp_entry = {8'h00, 1'b1, head[26]};
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_apb_proc_driver.sv
// tb/tb_apb_proc_driver.sv - self-checking bench for apb_proc_driver with a transfer-level reference model
module tb_apb_proc_driver;
   localparam int DP = 4;
   localparam int TO = 4;

   typedef struct {
      logic       w;
      logic [1:0] sel;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] wt;
      int         k;
      logic [7:0] rd;
   } xfer_t;

   logic       clk, rst_n;
   logic       cmd_valid, cmd_ready, cmd_write;
   logic [1:0] cmd_sel;
   logic [7:0] cmd_addr, cmd_wdata, cmd_wait;
   logic       rsp_valid, rsp_ready, rsp_err, rsp_write, busy;
   logic [7:0] rsp_data;

   apb_proc_driver_if pb_if ();

   apb_proc_driver #(.DEPTH(DP), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wait(cmd_wait),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_err(rsp_err), .rsp_write(rsp_write), .busy(busy), .pb(pb_if)
   );

   int         n_checks = 0;
   int         n_err = 0;
   int         cyc = 0;
   int         n_starts = 0;
   int         last_start = 0;
   int         acc_cyc = 0;
   int         rsp_mode = 1;
   xfer_t      plan[$];
   logic [9:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   // a transfer completes only if ready lands within the cmd_wait+TIMEOUT+1 WAIT cycles
   function automatic logic [9:0] model_rsp(input xfer_t x);
      if (x.sel == 2'd0) return {8'h00, 1'b1, x.w};
      if (x.k != 0 && x.k <= int'(x.wt) + TO + 1) return {(x.w ? 8'h00 : x.rd), 1'b0, x.w};
      return {8'h00, 1'b1, x.w};
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      rsp_ready = 1'b0;
      forever begin
         @(negedge clk);
         case (rsp_mode)
            0:       rsp_ready = 1'b0;
            1:       rsp_ready = 1'b1;
            default: rsp_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   initial forever begin
      @(negedge clk);
      #1;
      if (rst_n && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
         else check("rsp", {rsp_data, rsp_err, rsp_write}, exp_q.pop_front());
      end
   end

   // slave: answers the n-th start with the n-th planned latency (k=0 never answers)
   initial begin
      xfer_t cur;
      int    countdown;
      logic  prev_start;
      countdown = 0;
      prev_start = 1'b0;
      cur = '{1'b0, 2'd0, 8'h00, 8'h00, 8'h00, 0, 8'h00};
      pb_if.ready = 1'b0;
      pb_if.rdata = 8'h00;
      forever begin
         @(negedge clk);
         pb_if.ready = 1'b0;
         if (!rst_n) begin
            countdown = 0;
            prev_start = 1'b0;
         end else begin
            if (countdown > 0) begin
               countdown--;
               if (countdown == 0) begin
                  pb_if.ready = 1'b1;
                  pb_if.rdata = cur.rd;
                  if (!pb_if.start)
                     check("held_fields", {pb_if.write, pb_if.sel, pb_if.addr, pb_if.wdata, pb_if.wait_cycles},
                           {cur.w, cur.sel, cur.addr, cur.wdata, cur.wt});
               end
            end
            if (pb_if.start) begin
               check("start_pulse", prev_start, 0);
               n_starts++;
               last_start = cyc;
               if (plan.size() == 0) begin
                  check("start_unplanned", 1, 0);
               end else begin
                  cur = plan.pop_front();
                  check("start_fields", {pb_if.write, pb_if.sel, pb_if.addr, pb_if.wdata, pb_if.wait_cycles},
                        {cur.w, cur.sel, cur.addr, cur.wdata, cur.wt});
                  countdown = cur.k;
               end
            end
            prev_start = pb_if.start;
         end
      end
   end

   task automatic push_cmd(input logic w, input logic [1:0] sel, input logic [7:0] addr,
                           input logic [7:0] wdata, input logic [7:0] wt, input int k, input logic [7:0] rd);
      xfer_t x;
      int    n;
      x = '{w, sel, addr, wdata, wt, k, rd};
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_sel   = sel;
      cmd_addr  = addr;
      cmd_wdata = wdata;
      cmd_wait  = wt;
      n = 0;
      while (!cmd_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("cmd_accept_timeout", n < 500, 1);
      acc_cyc = cyc;
      if (sel != 2'd0) plan.push_back(x);
      exp_q.push_back(model_rsp(x));
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy || rsp_valid || exp_q.size() != 0) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", n < 2000, 1);
   endtask

   task automatic wait_rsp_valid(output int n);
      n = 0;
      while (!rsp_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      int n, base;
      logic       w;
      logic [1:0] sel;
      logic [7:0] wt;
      int         k;
      rst_n = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_sel = 2'd0;
      cmd_addr = 8'h00;
      cmd_wdata = 8'h00;
      cmd_wait = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_pb", {pb_if.start, pb_if.write, pb_if.sel, pb_if.addr, pb_if.wdata, pb_if.wait_cycles}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      push_cmd(1'b1, 2'd1, 8'h10, 8'hA5, 8'd0, 3, 8'h00);
      wait_idle();
      check("accept_to_start", last_start - acc_cyc, 2);

      push_cmd(1'b0, 2'd2, 8'h33, 8'h00, 8'd2, 2, 8'h5C);
      wait_rsp_valid(n);
      check("read_busy_drop", busy, 0);
      wait_idle();

      base = n_starts;
      push_cmd(1'b0, 2'd0, 8'h44, 8'h00, 8'd0, 0, 8'h00);
      wait_rsp_valid(n);
      check("reject_latency", n, 2);
      wait_idle();
      check("reject_no_start", n_starts - base, 0);

      push_cmd(1'b0, 2'd1, 8'h21, 8'h00, 8'd3, 0, 8'h00);
      while (n_starts == base && n < 100) begin
         @(negedge clk);
         n++;
      end
      wait_rsp_valid(n);
      check("timeout_latency", cyc - last_start, 9);
      wait_idle();
      push_cmd(1'b0, 2'd1, 8'h22, 8'h00, 8'd3, 8, 8'hE7);
      wait_idle();
      push_cmd(1'b1, 2'd3, 8'h23, 8'h5A, 8'd3, 9, 8'h00);
      wait_idle();

      rsp_mode = 0;
      repeat (2) @(negedge clk);
      base = n_starts;
      for (int i = 0; i < 4; i++)
         push_cmd(1'b0, 2'(1 + i % 3), 8'(8'h80 + i), 8'h00, 8'd5, int'($urandom_range(3, 5)), 8'($urandom));
      check("bp_cmd_ready_low", cmd_ready, 0);
      for (int i = 4; i < 6; i++)
         push_cmd(1'b0, 2'd2, 8'(8'h80 + i), 8'h00, 8'd5, int'($urandom_range(1, 5)), 8'($urandom));
      n = 0;
      while (n_starts - base < 4 && n < 500) begin
         @(negedge clk);
         n++;
      end
      repeat (30) @(negedge clk);
      check("bp_stall_starts", n_starts - base, 4);
      check("bp_stall_busy", {busy, rsp_valid}, 2'b11);
      rsp_mode = 1;
      wait_idle();
      check("bp_total_starts", n_starts - base, 6);

      base = n_starts;
      push_cmd(1'b1, 2'd3, 8'h77, 8'h99, 8'd20, 0, 8'h00);
      n = 0;
      while (n_starts == base && n < 100) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_outputs", {pb_if.start, pb_if.write, pb_if.sel, pb_if.addr, pb_if.wdata, pb_if.wait_cycles,
                               rsp_valid, busy}, 0);
      check("midrst_cmd_ready", cmd_ready, 1);
      exp_q.delete();
      plan.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("midrst_no_rsp", {rsp_valid, cmd_ready}, 2'b01);
      push_cmd(1'b0, 2'd1, 8'h55, 8'h00, 8'd1, 2, 8'h3C);
      wait_idle();

      rsp_mode = 2;
      for (int i = 0; i < 24; i++) begin
         w   = 1'($urandom_range(0, 1));
         sel = 2'($urandom_range(0, 3));
         wt  = 8'($urandom_range(0, 5));
         k   = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, int'(wt) + TO + 3));
         push_cmd(w, sel, 8'($urandom), 8'($urandom), wt, k, 8'($urandom));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_idle();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule

// File: doc/apb_proc_driver.md
Name: apb_proc_driver

Overview:
- Processor-side initiator for the Processor_Bus processor modport.
- Accepts queued transfer commands from a local sequencer or CPU stub and drives start/sel/addr/wdata/write/wait_cycles into the APB master.
- Waits for ready, then returns read data and status through a response queue.
- Gives the APB master a well-formed request stream: one-cycle start pulses, held fields, invalid-sel rejection, and a completion timeout.

Parameters:
- DEPTH, 4, entries in each of the command FIFO and the response FIFO; power of 2, ≥2.
- TIMEOUT, 16, extra cycles allowed beyond cmd_wait before a transfer is aborted; range 1..255.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command FIFO not full.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_sel  in  2  target slave id; 0 is invalid.
- cmd_addr  in  8  transfer address.
- cmd_wdata  in  8  write data.
- cmd_wait  in  8  wait cycles requested of the slave.
- rsp_valid  out  1  response FIFO not empty.
- rsp_ready  in  1  response consumed.
- rsp_data  out  8  read data; 0 for writes and errors.
- rsp_err  out  1  1 = invalid sel or timeout.
- rsp_write  out  1  echo of the command's write bit.
- pb_start  out  1  transfer request to the APB master.
- pb_write  out  1  held command field.
- pb_sel  out  2  held command field.
- pb_addr  out  8  held command field.
- pb_wdata  out  8  held command field.
- pb_wait_cycles  out  8  held command field.
- pb_rdata  in  8  read data from the APB master.
- pb_ready  in  1  transfer-complete indication from the APB master.
- busy  out  1  high in any state other than IDLE, or when the command FIFO is non-empty.

Behaviour:
- Reset (reset=0, asynchronous): FSM returns to IDLE; both FIFOs are emptied and in-flight/queued commands are dropped.
  - pb_start, pb_write, pb_sel, pb_addr, pb_wdata, pb_wait_cycles, rsp_valid and busy go to 0; cmd_ready goes to 1.
  - Reset mid-transfer does not generate a response.
- Command FIFO:
  - Push when cmd_valid && cmd_ready; cmd_ready = !full, with no pass-through while full, even if a pop happens in the same cycle.
  - The FSM sees an entry on the cycle after the push (registered FIFO).
- Response FIFO:
  - Push is done only by the FSM; pop when rsp_valid && rsp_ready. Simultaneous push and pop are legal at any occupancy.
  - rsp_* fields are valid whenever rsp_valid=1 and stay stable until popped.
- FSM states: IDLE, START, WAIT, REJECT.
  - IDLE: when the command FIFO is non-empty and the response FIFO is not full:
    - head.sel == 0 -> REJECT.
    - otherwise -> START, registering pb_* from the head entry and setting pb_start=1.
    - The head entry is not popped yet.
  - START (exactly 1 cycle): pb_start=1 and fields valid. Load timeout counter = cmd_wait + TIMEOUT (10-bit, no overflow), then -> WAIT with pb_start=0.
  - WAIT: pb_start=0, pb_* fields held unchanged. Each cycle:
    - pb_ready=1 -> pop the command; push response {data = write ? 0 : pb_rdata, err=0, write}; -> IDLE.
    - else counter == 0 -> pop the command; push {0, err=1, write}; -> IDLE.
    - else decrement the counter.
    - pb_ready wins over expiry in the same cycle.
  - REJECT (1 cycle): pop the command, push {0, err=1, write}, -> IDLE. No pb_start is issued and pb_* fields are unchanged.
  - On leaving WAIT, pb_* fields hold their last values; they are only updated on entry to START.
- Ordering and latency:
  - Exactly one transfer is outstanding at a time. Responses are produced in command order, one per command.
  - Minimum command-accept to pb_start: 2 cycles.
  - Back-to-back transfers: after ready, the next pb_start comes no earlier than 2 cycles later, so the APB master always sees start=0 in its access phase and returns to idle.
- Full response FIFO: the FSM waits in IDLE with no start, so at most DEPTH responses are pending.
- pb_ready seen outside WAIT is ignored.

Test Plan:
- Reset, then a single write: cmd {w=1, sel=1, addr=0x10, wdata=0xA5, wait=0}; bench slave raises ready 3 cycles after start.
  -> One pb_start pulse; pb_addr=0x10 and pb_wdata=0xA5 held until ready; response {data=0x00, err=0, write=1}.
- Read: cmd {w=0, sel=2, addr=0x33, wait=2}; ready with pb_rdata=0x5C.
  -> Response {0x5C, 0, 0}; busy drops the cycle after completion.
- Invalid sel: cmd {sel=0, addr=0x44}.
  -> pb_start never asserts; response {0x00, err=1} one cycle after the entry is seen.
- Timeout: TIMEOUT=4, cmd wait=3, ready never asserted.
  -> Response {0, err=1} exactly 1+7+1 cycles after START.
  -> Same setup with ready asserted in the expiry cycle: err=0.
- Backpressure: DEPTH=4, 6 reads pushed with rsp_ready=0.
  -> cmd_ready low after 4 accepted; exactly 4 transfers run, then the FSM stalls in IDLE.
  -> Release rsp_ready: the remaining 2 complete; all 6 responses arrive in order with the correct data.
- Reset mid-transfer: assert reset during WAIT.
  -> All outputs 0 immediately; no response; cmd_ready=1 after release; a fresh command completes normally.
